// File: rtl/fetch_queue.sv
// Instruction fetch front end: issues in-order word fetches, queues returned words for decode,
// and discards stale responses after a redirect by counting them down in a DRAIN state.
module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        stallD,
    output logic        validF,
    output logic [31:0] instrF,
    output logic [31:0] pcplus4F
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [0:0] RUN   = 1'b0;
    localparam logic [0:0] DRAIN = 1'b1;

    logic [0:0]    state;
    logic [31:0]   fetch_pc;
    logic [CW-1:0] count;
    logic [CW-1:0] outst;
    logic [CW-1:0] drop_cnt;
    logic [CW-1:0] live_outst;
    logic [CW-1:0] redir_drop;

    logic [31:0]   q_instr [DEPTH];
    logic [31:0]   q_pc4   [DEPTH];
    logic [AW-1:0] q_head, q_tail;

    // Addresses of every outstanding request, live or stale; popped by each response.
    logic [31:0]   a_mem   [DEPTH];
    logic [AW-1:0] a_head, a_tail;

    logic xfer, resp_ok, push, pop;

    assign live_outst = outst - drop_cnt;

    assign imem_req_valid = !reset && !redirect_valid &&
                            (((CW+1)'(count) + (CW+1)'(live_outst)) < (CW+1)'(DEPTH));
    assign imem_req_addr  = fetch_pc;

    assign xfer    = imem_req_valid && imem_req_ready;
    assign resp_ok = imem_resp_valid && (outst != '0);
    assign push    = resp_ok && (drop_cnt == '0) && !redirect_valid;
    assign pop     = validF && !stallD && !redirect_valid;

    assign redir_drop = outst - CW'(resp_ok);

    assign validF   = (count != '0);
    assign instrF   = validF ? q_instr[q_head] : 32'h0;
    assign pcplus4F = validF ? q_pc4[q_head]   : 32'h0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= RUN;
            fetch_pc <= RESET_PC;
            count    <= '0;
            outst    <= '0;
            drop_cnt <= '0;
            q_head   <= '0;
            q_tail   <= '0;
            a_head   <= '0;
            a_tail   <= '0;
        end else begin
            outst <= outst + CW'(xfer) - CW'(resp_ok);
            if (xfer)    a_tail <= a_tail + AW'(1);
            if (resp_ok) a_head <= a_head + AW'(1);

            if (redirect_valid) begin
                // The response arriving now is already stale, so it is not counted for dropping.
                fetch_pc <= redirect_pc & 32'hFFFF_FFFC;
                count    <= '0;
                q_head   <= '0;
                q_tail   <= '0;
                drop_cnt <= redir_drop;
                state    <= (redir_drop != '0) ? DRAIN : RUN;
            end else begin
                if (xfer) fetch_pc <= fetch_pc + 32'd4;
                if (push) q_tail   <= q_tail + AW'(1);
                if (pop)  q_head   <= q_head + AW'(1);
                count <= count + CW'(push) - CW'(pop);
                if (resp_ok && (drop_cnt != '0)) begin
                    drop_cnt <= drop_cnt - CW'(1);
                    if (drop_cnt == CW'(1)) state <= RUN;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_instr[q_tail] <= imem_resp_data;
            q_pc4[q_tail]   <= a_mem[a_head] + 32'd4;
        end
        if (xfer) a_mem[a_tail] <= fetch_pc;
    end

    resp_no_outst: assert property (@(posedge clk) disable iff (reset)
        !(imem_resp_valid && (outst == '0)));

endmodule
